// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, state encoding and datapath control encodings for the multicycle MIPS sequencer
package mc_ctrl_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4, MEMWB = 4'd5,
    MEMWR = 4'd6, EXEC = 4'd7, RWB = 4'd8, BRANCH = 4'd9, IEXEC = 4'd10, IWB = 4'd11, FAULT = 4'd15
  } state_t;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_SLT = 2'b11} alu_op_t;
  typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11} src_b_t;
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    src_b_t     alu_src_b;
    alu_op_t    alu_op;
    logic [1:0] pc_source;
    logic       fault;
  } ctl_t;
  // Moore part of the control word; the mem_ready/zero dependent strobes live in the top
  function automatic ctl_t decode(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; end
      DECODE: c.alu_src_b = SRCB_IMM_SH;
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
      MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = ALU_FUNCT; end
      RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_source = 2'b01; end
      IEXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_SLT; end
      IWB:    c.reg_write = 1'b1;
      FAULT:  c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control bus between the sequencer (master) and the shared datapath (slave)
interface mc_ctrl_if #(parameter int OP_W = 6);
  logic [OP_W-1:0] op;
  logic            zero, mem_ready;
  logic            pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]      alu_src_b, alu_op, pc_source;
  logic            illegal_op, fault;
  modport master (input op, zero, mem_ready,
                  output pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                         alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, fault);
  modport slave  (output op, zero, mem_ready,
                  input  pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                         alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, fault);
endinterface

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: saturating memory-wait counter flagging the last allowed stall cycle
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
  assign expired = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control sequencer with memory-stall timeout fault
module mc_control_fsm import mc_ctrl_pkg::*; #(
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input logic      clk,
  input logic      rst_n,
  mc_ctrl_if.master bus
);
  state_t state, nxt;
  ctl_t   ctl;
  logic   expired, legal, mem_state, fetch_done;
  assign legal = bus.op inside {OP_W'(OP_R), OP_W'(OP_LW), OP_W'(OP_SW), OP_W'(OP_BEQ), OP_W'(OP_SLTI)};
  assign mem_state = state inside {FETCH, MEMRD, MEMWR};
  assign fetch_done = (state == FETCH) && bus.mem_ready;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = FETCH;
      FETCH:  nxt = bus.mem_ready ? DECODE : expired ? FAULT : FETCH;
      DECODE: nxt = bus.op == OP_W'(OP_R)    ? EXEC   :
                    bus.op == OP_W'(OP_BEQ)  ? BRANCH :
                    bus.op == OP_W'(OP_SLTI) ? IEXEC  :
                    legal                    ? MEMADR : FETCH;
      MEMADR: nxt = bus.op == OP_W'(OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = bus.mem_ready ? MEMWB : expired ? FAULT : MEMRD;
      MEMWR:  nxt = bus.mem_ready ? FETCH : expired ? FAULT : MEMWR;
      EXEC:   nxt = RWB;
      IEXEC:  nxt = IWB;
      FAULT:  nxt = FAULT;
      default: nxt = state inside {MEMWB, RWB, BRANCH, IWB} ? FETCH : IDLE;
    endcase
  end
  // Any state change restarts the count, so each memory state starts its own budget
  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr(nxt != state), .inc(mem_state && !bus.mem_ready), .expired(expired)
  );
  // Control word is registered from the next state so it tracks the state register exactly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ctl   <= '0;
    end else begin
      state <= nxt;
      ctl   <= decode(nxt);
    end
  assign bus.iord       = ctl.iord;
  assign bus.mem_read   = ctl.mem_read;
  assign bus.mem_write  = ctl.mem_write;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.reg_dst    = ctl.reg_dst;
  assign bus.reg_write  = ctl.reg_write;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.pc_source  = ctl.pc_source;
  assign bus.fault      = ctl.fault;
  assign bus.ir_write   = fetch_done;
  assign bus.pc_write   = fetch_done || (state == BRANCH && bus.zero);
  assign bus.illegal_op = (state == DECODE) && !legal;
endmodule
